// File: rtl/mig1_run_ctrl.sv
// mig1_run_ctrl: run/reset sequencer for the Mig1 core.
// Stretches the system reset into an active-low core reset (HOLD), clocks
// the core for RUN_CYCLES enabled cycles (RUN), then parks in DONE.
// Every output is a register loaded from the next-state logic below.
`timescale 1ns/1ps

module mig1_run_ctrl #(
  parameter int HOLD_CYCLES = 4,   // core reset low time after reset deasserts
  parameter int RUN_CYCLES  = 10,  // enabled cycles before DONE; 0 = forever
  parameter int CNT_W       = 16   // hold/run counter width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             restart,
  output logic             core_reset_n,
  output logic             core_clk_en,
  output logic             run_active,
  output logic             done,
  output logic [CNT_W-1:0] run_count
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES);
  localparam bit               RUN_FOREVER = (RUN_CYCLES == 0);

  state_t           state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
  logic [CNT_W-1:0] run_count_nx;
  logic [CNT_W-1:0] run_inc;
  logic             core_reset_n_nx;
  logic             core_clk_en_nx;
  logic             run_active_nx;
  logic             done_nx;

  // Wraps naturally at 2^CNT_W, which is what run-forever mode relies on.
  assign run_inc = run_count + CNT_W'(1);

  // Next-state and next-output decode; restart outranks halt, halt outranks counting.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    state_nx        = state;
    hold_cnt_nx     = hold_cnt;
    run_count_nx    = run_count;
    core_reset_n_nx = core_reset_n;
    core_clk_en_nx  = core_clk_en;
    run_active_nx   = run_active;
    done_nx         = done;

    case (state)
      ST_HOLD: begin
        // The core is clocked while held in reset; halt/restart are ignored.
        core_reset_n_nx = 1'b0;
        core_clk_en_nx  = 1'b1;
        run_active_nx   = 1'b0;
        done_nx         = 1'b0;
        if (hold_cnt == HOLD_LAST) begin
          state_nx        = ST_RUN;
          core_reset_n_nx = 1'b1;
          hold_cnt_nx     = '0;
        end else begin
          hold_cnt_nx = hold_cnt + CNT_W'(1);
        end
      end

      ST_RUN: begin
        core_reset_n_nx = 1'b1;
        done_nx         = 1'b0;
        if (restart) begin
          state_nx        = ST_HOLD;
          hold_cnt_nx     = '0;
          run_count_nx    = '0;
          core_reset_n_nx = 1'b0;
          core_clk_en_nx  = 1'b1;
          run_active_nx   = 1'b0;
        end else if (halt) begin
          // Pausing drops the enable and freezes the count.
          core_clk_en_nx = 1'b0;
          run_active_nx  = 1'b0;
        end else begin
          run_count_nx = run_inc;
          if (!RUN_FOREVER && run_inc == RUN_LAST) begin
            state_nx       = ST_DONE;
            done_nx        = 1'b1;
            core_clk_en_nx = 1'b0;
            run_active_nx  = 1'b0;
          end else begin
            core_clk_en_nx = 1'b1;
            run_active_nx  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // Parked: run_count stays at RUN_CYCLES until a restart.
        core_reset_n_nx = 1'b1;
        core_clk_en_nx  = 1'b0;
        run_active_nx   = 1'b0;
        done_nx         = 1'b1;
        if (restart) begin
          state_nx        = ST_HOLD;
          hold_cnt_nx     = '0;
          run_count_nx    = '0;
          core_reset_n_nx = 1'b0;
          core_clk_en_nx  = 1'b1;
          done_nx         = 1'b0;
        end
      end

      default: begin
        state_nx        = ST_HOLD;
        hold_cnt_nx     = '0;
        run_count_nx    = '0;
        core_reset_n_nx = 1'b0;
        core_clk_en_nx  = 1'b0;
        run_active_nx   = 1'b0;
        done_nx         = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state        <= ST_HOLD;
      hold_cnt     <= '0;
      run_count    <= '0;
      core_reset_n <= 1'b0;
      core_clk_en  <= 1'b0;
      run_active   <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      hold_cnt     <= hold_cnt_nx;
      run_count    <= run_count_nx;
      core_reset_n <= core_reset_n_nx;
      core_clk_en  <= core_clk_en_nx;
      run_active   <= run_active_nx;
      done         <= done_nx;
    end
  end

  // Parameter legality and output invariants (ignored by synthesis).
  a_hold_min: assert property (@(posedge clk) HOLD_CYCLES >= 1);
  a_run_fits: assert property (@(posedge clk) 64'(RUN_CYCLES) < (64'd1 << CNT_W));
  a_excl:     assert property (@(posedge clk) disable iff (reset) !(done && run_active));
  a_rst_idle: assert property (@(posedge clk) disable iff (reset) (!core_reset_n) |-> !run_active);

endmodule

// File: tb/tb_mig1_run_ctrl.sv
// tb_mig1_run_ctrl: directed bench for mig1_run_ctrl.
// Instance a uses the defaults (4/10/16); instance b runs forever (4/0/4).
// A per-edge behavioural model is compared on every falling edge, and the
// directed sequence pins key cycle positions with literal expectations.
`timescale 1ns/1ps

module tb_mig1_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, halt, restart;
  logic        reset_b, halt_b, restart_b;
  logic        a_core_reset_n, a_core_clk_en, a_run_active, a_done;
  logic [15:0] a_run_count;
  logic        b_core_reset_n, b_core_clk_en, b_run_active, b_done;
  logic [3:0]  b_run_count;

  int total = 0;
  int bad   = 0;
  bit mvalid = 1'b0;
  bit b_finished = 1'b0;

  always #5 clk = ~clk;

  mig1_run_ctrl #(.HOLD_CYCLES(4), .RUN_CYCLES(10), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .halt(halt), .restart(restart),
    .core_reset_n(a_core_reset_n), .core_clk_en(a_core_clk_en),
    .run_active(a_run_active), .done(a_done), .run_count(a_run_count)
  );

  mig1_run_ctrl #(.HOLD_CYCLES(4), .RUN_CYCLES(0), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset_b), .halt(halt_b), .restart(restart_b),
    .core_reset_n(b_core_reset_n), .core_clk_en(b_core_clk_en),
    .run_active(b_run_active), .done(b_done), .run_count(b_run_count)
  );

  // ---------------- behavioural model ----------------
  typedef enum {M_HOLD, M_RUN, M_DONE} mphase_t;
  typedef struct {
    mphase_t ph;
    int      held;
    int      count;
    bit      rst_n;
    bit      clk_en;
    bit      active;
    bit      done;
  } mstate_t;

  mstate_t ma, mb;

  // Expected outputs after one clock edge given the inputs sampled there.
  function automatic mstate_t step(mstate_t s, bit rst, bit hlt, bit rs,
                                   int hold_c, int run_c, int cnt_w);
    mstate_t n = s;
    mstate_t to_hold = '{M_HOLD, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    if (rst) return '{M_HOLD, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    case (s.ph)
      M_HOLD: begin
        n.held   = s.held + 1;
        n.clk_en = 1'b1;
        if (n.held == hold_c) begin
          n.ph    = M_RUN;
          n.rst_n = 1'b1;
          n.held  = 0;
        end
      end
      M_RUN: begin
        if (rs) n = to_hold;
        else if (hlt) begin
          n.clk_en = 1'b0;
          n.active = 1'b0;
        end else begin
          n.count = (s.count + 1) % (1 << cnt_w);
          if (run_c != 0 && n.count == run_c) begin
            n.ph = M_DONE; n.done = 1'b1; n.clk_en = 1'b0; n.active = 1'b0;
          end else begin
            n.clk_en = 1'b1; n.active = 1'b1;
          end
        end
      end
      default: if (rs) n = to_hold;
    endcase
    return n;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on every rising edge.
  always @(posedge clk) begin
    ma     <= step(ma, reset, halt, restart, 4, 10, 16);
    mb     <= step(mb, reset_b, halt_b, restart_b, 4, 0, 4);
    mvalid <= 1'b1;
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (mvalid) begin
      check("a_core_reset_n", a_core_reset_n, ma.rst_n);
      check("a_core_clk_en",  a_core_clk_en,  ma.clk_en);
      check("a_run_active",   a_run_active,   ma.active);
      check("a_done",         a_done,         ma.done);
      check("a_run_count",    a_run_count,    ma.count);
      check("b_core_reset_n", b_core_reset_n, mb.rst_n);
      check("b_core_clk_en",  b_core_clk_en,  mb.clk_en);
      check("b_run_active",   b_run_active,   mb.active);
      check("b_done",         b_done,         mb.done);
      check("b_run_count",    b_run_count,    mb.count);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rst_n"},  a_core_reset_n, 0);
    check({tag, "_clk_en"}, a_core_clk_en,  0);
    check({tag, "_active"}, a_run_active,   0);
    check({tag, "_done"},   a_done,         0);
    check({tag, "_count"},  a_run_count,    0);
  endtask

  // Called just after the edge that entered HOLD; covers the 4 hold edges.
  // With noise set, halt and restart are driven high for the first 3.
  task automatic hold_phase(input bit noise);
    if (noise) begin
      halt    = 1'b1;
      restart = 1'b1;
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("hold_rst_n",  a_core_reset_n, 0);
      check("hold_clk_en", a_core_clk_en,  1);
    end
    halt    = 1'b0;
    restart = 1'b0;
    tick();
    check("release_rst_n",  a_core_reset_n, 1);
    check("release_active", a_run_active,   0);
    check("release_count",  a_run_count,    0);
  endtask

  task automatic run_until_count(input int target, output int n);
    n = 0;
    while (a_run_count != 16'(target) && n < 64) begin
      tick();
      n++;
    end
    check("reach_count", a_run_count, target);
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    while (!a_done && n < 64) begin
      tick();
      n++;
    end
    check("done_seen", a_done, 1);
  endtask

  // ---------------- instance a: main sequence ----------------
  initial begin
    int n;
    reset = 1'b1; halt = 1'b0; restart = 1'b0;
    reset_b = 1'b1; halt_b = 1'b0; restart_b = 1'b0;

    // Case 1: reset for 3 edges, hold 4 edges, run 10 enabled cycles.
    repeat (3) tick();
    check_reset_values("por");
    reset   = 1'b0;
    reset_b = 1'b0;
    hold_phase(1'b0);
    tick();
    check("run1_first_active", a_run_active, 1);
    check("run1_first_count",  a_run_count,  1);
    run_to_done(n);
    check("run1_len",    n,             9);
    check("run1_count",  a_run_count,   10);
    check("run1_clk_en", a_core_clk_en, 0);
    repeat (20) tick();
    check("done_held",        a_done,        1);
    check("done_held_clk_en", a_core_clk_en, 0);
    check("done_held_count",  a_run_count,   10);

    // Case 3: one-cycle restart from DONE, then case 2 halt inside the new run.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_done",   a_done,         0);
    check("restart_rst_n",  a_core_reset_n, 0);
    check("restart_clk_en", a_core_clk_en,  1);
    check("restart_count",  a_run_count,    0);
    hold_phase(1'b0);
    run_until_count(5, n);
    check("to_five", n, 5);
    halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halt_count",  a_run_count,   5);
      check("halt_clk_en", a_core_clk_en, 0);
      check("halt_active", a_run_active,  0);
    end
    halt = 1'b0;
    run_to_done(n);
    // Case 1 took 10 edges from hold release to DONE; 3 halted edges add 3.
    check("run2_len",   5 + 3 + n,   13);
    check("run2_count", a_run_count, 10);

    // Case 4: reset mid-run at count 7, then full replay.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    hold_phase(1'b1);
    run_until_count(7, n);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midrun");
    hold_phase(1'b0);
    run_to_done(n);
    check("run3_len",   n,           10);
    check("run3_count", a_run_count, 10);

    // Case 5: restart on the final-increment edge wins.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    hold_phase(1'b0);
    run_until_count(9, n);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("race_rst_n",  a_core_reset_n, 0);
    check("race_count",  a_run_count,    0);
    check("race_done",   a_done,         0);
    check("race_clk_en", a_core_clk_en,  1);
    hold_phase(1'b0);

    // halt on the final-count edge suppresses the increment.
    run_until_count(9, n);
    halt = 1'b1;
    tick();
    check("halt_final_count", a_run_count, 9);
    check("halt_final_done",  a_done,      0);
    halt = 1'b0;
    tick();
    check("after_halt_done",  a_done,      1);
    check("after_halt_count", a_run_count, 10);

    n = 0;
    while (!b_finished && n < 200) begin
      tick();
      n++;
    end
    check("b_finished", b_finished, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- instance b: run forever, 4-bit wrap ----------------
  initial begin
    repeat (3) tick();
    for (int k = 1; k <= 45; k++) begin
      tick();
      check("b_never_done", b_done, 0);
      if (k == 4)  check("b_release",  b_core_reset_n, 1);
      if (k == 19) check("b_cnt_max",  b_run_count,    15);
      if (k == 20) check("b_cnt_wrap", b_run_count,    0);
      if (k == 36) check("b_cnt_wrap2", b_run_count,   0);
    end
    b_finished = 1'b1;
  end

endmodule
